// File: rtl/game_loop_scheduler.sv
// game_loop_scheduler
//   Per-frame sequencer for the BrickBreaker datapath. After the initial brick store/draw
//   finishes it runs an internal frame timer; every frame it issues paddle erase/move/draw,
//   and every BALL_DIV frames it also issues ball erase/move/(brick erase)/draw. Operations
//   are issued one at a time on an op_sel/op_start/op_done handshake.
//
// Ports
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_init_done    level: initial RAM store + brick draw finished
//   i_op_done      pulse from datapath: current operation complete
//   i_brick_hit    from datapath, only meaningful with i_op_done while moving the ball
//   o_op_sel       current op (0 none, 1 EP, 2 MP, 3 DP, 4 EB, 5 MB, 6 EK, 7 DB)
//   o_op_start     one-cycle pulse in the first cycle of each op
//   o_busy         high while any op is in progress
//   o_overrun      sticky: a frame tick was lost
//   o_timeout_err  sticky: an op exceeded TIMEOUT cycles without op_done
module game_loop_scheduler #(
  parameter int unsigned FRAME_CYCLES = 833333,
  parameter int unsigned BALL_DIV     = 15,
  parameter int unsigned TIMEOUT      = 65535
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_init_done,
  input  logic       i_op_done,
  input  logic       i_brick_hit,
  output logic [2:0] o_op_sel,
  output logic       o_op_start,
  output logic       o_busy,
  output logic       o_overrun,
  output logic       o_timeout_err
);

  localparam int unsigned FcW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int unsigned BcW = (BALL_DIV > 1) ? $clog2(BALL_DIV) : 1;
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  localparam logic [FcW-1:0] FcLast  = FcW'(FRAME_CYCLES - 1);
  localparam logic [BcW-1:0] BcLast  = BcW'(BALL_DIV - 1);
  localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT);

  typedef enum logic [3:0] {
    StWaitInit,
    StIdle,
    StEp,
    StMp,
    StDp,
    StEb,
    StMb,
    StEk,
    StDb
  } state_e;

  function automatic logic [2:0] op_code(input state_e s);
    logic [2:0] code;
    case (s)
      StEp:    code = 3'd1;
      StMp:    code = 3'd2;
      StDp:    code = 3'd3;
      StEb:    code = 3'd4;
      StMb:    code = 3'd5;
      StEk:    code = 3'd6;
      StDb:    code = 3'd7;
      default: code = 3'd0;
    endcase
    return code;
  endfunction

  state_e         r_state;
  logic [FcW-1:0] r_frame_cnt;
  logic [BcW-1:0] r_ball_cnt;
  logic [WdW-1:0] r_wd_cnt;
  logic           r_ball_due;
  logic           r_tick_pending;
  logic [2:0]     r_op_sel;
  logic           r_op_start;
  logic           r_busy;
  logic           r_overrun;
  logic           r_timeout_err;

  state_e         w_state_next;
  logic [FcW-1:0] w_frame_cnt_next;
  logic [BcW-1:0] w_ball_cnt_next;
  logic [WdW-1:0] w_wd_cnt_next;
  logic           w_ball_due_next;
  logic           w_tick_pending_next;
  logic [2:0]     w_op_sel_next;
  logic           w_op_start_next;
  logic           w_busy_next;
  logic           w_overrun_next;
  logic           w_timeout_err_next;
  logic           w_tick;
  logic           w_in_op;
  logic           w_done;

  always_comb begin
    w_state_next        = r_state;
    w_ball_cnt_next     = r_ball_cnt;
    w_ball_due_next     = r_ball_due;
    w_tick_pending_next = r_tick_pending;
    w_overrun_next      = r_overrun;
    w_timeout_err_next  = r_timeout_err;

    w_tick  = (r_state != StWaitInit) && (r_frame_cnt == FcLast);
    w_in_op = (op_code(r_state) != 3'd0);
    // op_done in the op_start cycle belongs to no op yet and is ignored
    w_done  = w_in_op && i_op_done && !r_op_start;

    if (r_state == StWaitInit || w_tick) begin
      w_frame_cnt_next = '0;
    end else begin
      w_frame_cnt_next = r_frame_cnt + 1'b1;
    end

    case (r_state)
      StWaitInit: if (i_init_done) w_state_next = StIdle;
      StIdle: begin
        if (r_tick_pending || w_tick) begin
          w_state_next        = StEp;
          // consuming a pending tick while a fresh one arrives re-pends the fresh one
          w_tick_pending_next = r_tick_pending && w_tick;
          w_ball_due_next     = (r_ball_cnt == BcLast);
          w_ball_cnt_next     = (r_ball_cnt == BcLast) ? '0 : r_ball_cnt + 1'b1;
        end
      end
      StEp: if (w_done) w_state_next = StMp;
      StMp: if (w_done) w_state_next = StDp;
      StDp: if (w_done) w_state_next = r_ball_due ? StEb : StIdle;
      StEb: if (w_done) w_state_next = StMb;
      StMb: if (w_done) w_state_next = i_brick_hit ? StEk : StDb;
      StEk: if (w_done) w_state_next = StDb;
      StDb: if (w_done) w_state_next = StIdle;
      default: w_state_next = StWaitInit;
    endcase

    if (w_tick && r_state != StIdle) begin
      if (r_tick_pending) begin
        w_overrun_next = 1'b1;
      end else begin
        w_tick_pending_next = 1'b1;
      end
    end

    // Watchdog abort drops the rest of this frame's sequence
    if (w_in_op && !w_done && r_wd_cnt == WdLimit) begin
      w_state_next       = StIdle;
      w_timeout_err_next = 1'b1;
    end

    if (w_state_next != r_state || !w_in_op) begin
      w_wd_cnt_next = '0;
    end else begin
      w_wd_cnt_next = r_wd_cnt + 1'b1;
    end

    w_op_sel_next   = op_code(w_state_next);
    w_busy_next     = (w_op_sel_next != 3'd0);
    w_op_start_next = w_busy_next && (w_state_next != r_state);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= StWaitInit;
      r_frame_cnt    <= '0;
      r_ball_cnt     <= '0;
      r_wd_cnt       <= '0;
      r_ball_due     <= 1'b0;
      r_tick_pending <= 1'b0;
      r_op_sel       <= 3'd0;
      r_op_start     <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_frame_cnt    <= w_frame_cnt_next;
      r_ball_cnt     <= w_ball_cnt_next;
      r_wd_cnt       <= w_wd_cnt_next;
      r_ball_due     <= w_ball_due_next;
      r_tick_pending <= w_tick_pending_next;
      r_op_sel       <= w_op_sel_next;
      r_op_start     <= w_op_start_next;
      r_busy         <= w_busy_next;
      r_overrun      <= w_overrun_next;
      r_timeout_err  <= w_timeout_err_next;
    end
  end

  assign o_op_sel      = r_op_sel;
  assign o_op_start    = r_op_start;
  assign o_busy        = r_busy;
  assign o_overrun     = r_overrun;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_game_loop_scheduler.sv
// Bench for game_loop_scheduler (FRAME_CYCLES=20, BALL_DIV=3, TIMEOUT=8). A datapath
// responder answers each op_start after a scripted delay (0 = never). A frame-level model
// derives the expected op_sel/op_start/busy/flag timeline per cycle from tick times and
// op durations.
module tb_game_loop_scheduler;

  localparam int FC   = 20;
  localparam int BD   = 3;
  localparam int TO   = 8;
  localparam int MAXC = 2048;

  logic       clk;
  logic       i_reset = 1'b1;
  logic       i_init_done = 1'b0;
  logic       i_op_done = 1'b0;
  logic       i_brick_hit = 1'b0;
  logic [2:0] o_op_sel;
  logic       o_op_start;
  logic       o_busy;
  logic       o_overrun;
  logic       o_timeout_err;

  game_loop_scheduler #(
    .FRAME_CYCLES(FC),
    .BALL_DIV    (BD),
    .TIMEOUT     (TO)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_init_done  (i_init_done),
    .i_op_done    (i_op_done),
    .i_brick_hit  (i_brick_hit),
    .o_op_sel     (o_op_sel),
    .o_op_start   (o_op_start),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun),
    .o_timeout_err(o_timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // scripted per-op delays (in issue order) and brick_hit values (one per ball move)
  int dly[$];
  bit hits[$];
  int rsp_di = 0;
  int rsp_hi = 0;
  bit glitch_en = 1'b0;
  bit noise_en = 1'b0;

  logic [2:0] exp_sel [MAXC];
  bit         exp_st  [MAXC];
  int exp_ov, exp_to, opi, bfi, model_end;

  // datapath responder
  initial begin : responder
    int d;
    logic [2:0] op;
    bit h;
    forever begin
      @(negedge clk);
      if (o_op_start === 1'b1) begin
        op = o_op_sel;
        if (rsp_di < dly.size()) begin d = dly[rsp_di]; rsp_di++; end
        else d = 2;
        h = 1'b0;
        if (op == 3'd5 && rsp_hi < hits.size()) begin h = hits[rsp_hi]; rsp_hi++; end
        i_op_done   = glitch_en && ($urandom_range(0, 1) == 1);
        i_brick_hit = 1'($urandom_range(0, 1));
        for (int i = 1; i <= d; i++) begin
          @(negedge clk);
          i_op_done   = (i == d);
          i_brick_hit = (i == d && op == 3'd5) ? h : 1'($urandom_range(0, 1));
        end
      end else begin
        i_op_done   = (o_busy === 1'b0) && noise_en && ($urandom_range(0, 3) == 0);
        i_brick_hit = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s cyc %0d observed %0h expected %0h", tag, cyc, got, expv);
    end
  endtask

  task automatic chk_zero();
    chk("rst_op_sel", 32'(o_op_sel), 0);
    chk("rst_op_start", 32'(o_op_start), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_overrun", 32'(o_overrun), 0);
    chk("rst_timeout", 32'(o_timeout_err), 0);
  endtask

  // one op of duration d cycles after start (d==0: never completes -> watchdog abort)
  task automatic m_op(input int op, inout int s, inout bit ab);
    int d;
    if (!ab) begin
      d = (opi < dly.size()) ? dly[opi] : 2;
      opi++;
      exp_st[s] = 1'b1;
      if (d == 0) begin
        for (int c = s; c <= s + TO; c++) exp_sel[c] = 3'(op);
        if (s + TO + 1 < exp_to) exp_to = s + TO + 1;
        s  = s + TO + 1;
        ab = 1'b1;
      end else begin
        for (int c = s; c <= s + d; c++) exp_sel[c] = 3'(op);
        s = s + d + 1;
      end
    end
  endtask

  // i0: first IDLE cycle; n: frames to model
  task automatic model(input int i0, input int n);
    int nt, idle_at, s;
    bit pend, ab, h;
    for (int c = 0; c < MAXC; c++) begin exp_sel[c] = 3'd0; exp_st[c] = 1'b0; end
    exp_ov = MAXC; exp_to = MAXC; opi = 0; bfi = 0;
    nt = i0 + FC - 1; pend = 1'b0; idle_at = i0;
    for (int f = 1; f <= n; f++) begin
      if (pend) begin s = idle_at + 1; pend = 1'b0; end
      else begin s = nt + 1; nt += FC; end
      ab = 1'b0; h = 1'b0;
      m_op(1, s, ab); m_op(2, s, ab); m_op(3, s, ab);
      if (f % BD == 0) begin
        m_op(4, s, ab);
        if (!ab) begin h = (bfi < hits.size()) ? hits[bfi] : 1'b0; bfi++; end
        m_op(5, s, ab);
        if (h) m_op(6, s, ab);
        m_op(7, s, ab);
      end
      idle_at = s;
      // ticks arriving while the frame was running
      while (nt <= idle_at - 1) begin
        if (pend) begin if (nt + 1 < exp_ov) exp_ov = nt + 1; end
        else pend = 1'b1;
        nt += FC;
      end
    end
    model_end = idle_at;
  endtask

  task automatic check_window(input int from, input int to);
    for (int c = from; c <= to; c++) begin
      while (cyc < c) @(negedge clk);
      chk("op_sel", 32'(o_op_sel), 32'(exp_sel[c]));
      chk("op_start", 32'(o_op_start), 32'(exp_st[c]));
      chk("busy", 32'(o_busy), 32'(exp_sel[c] != 3'd0));
      chk("overrun", 32'(o_overrun), 32'(c >= exp_ov));
      chk("timeout_err", 32'(o_timeout_err), 32'(c >= exp_to));
    end
  endtask

  task automatic do_reset(output int r);
    @(negedge clk);
    i_reset = 1'b1;
    i_init_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_zero();
    end
    i_reset = 1'b0;
    r = cyc;
  endtask

  initial begin : main
    int r, w, cm;

    // Phase A: 7 frames, random short delays, random brick hits, done glitches and noise
    dly.delete(); hits.delete();
    for (int k = 0; k < 50; k++) dly.push_back(int'($urandom_range(1, 2)));
    for (int k = 0; k < 4; k++) hits.push_back(1'($urandom_range(0, 1)));
    glitch_en = 1'b1; noise_en = 1'b1;
    do_reset(r);
    rsp_di = 0; rsp_hi = 0;
    w = r + 5;
    model(w + 1, 7);
    check_window(r + 1, w);
    i_init_done = 1'b1;
    check_window(w + 1, w + 25);
    i_init_done = 1'b0;
    check_window(w + 26, model_end);

    // Phase B: ball frame with ops at the TIMEOUT boundary -> pending tick, then overrun
    dly.delete(); hits.delete();
    for (int k = 0; k < 6; k++) dly.push_back(int'($urandom_range(1, 2)));
    for (int k = 0; k < 7; k++) dly.push_back(TO);
    hits.push_back(1'b1);
    do_reset(r);
    rsp_di = 0; rsp_hi = 0;
    w = r + int'($urandom_range(1, 6));
    model(w + 1, 4);
    check_window(r + 1, w);
    i_init_done = 1'b1;
    check_window(w + 1, model_end);

    // Phase C: MP never completes (watchdog), then reset during MB with op_done high
    dly.delete(); hits.delete();
    dly.push_back(int'($urandom_range(1, 2)));
    dly.push_back(0);
    for (int k = 0; k < 3; k++) dly.push_back(int'($urandom_range(1, 2)));
    for (int k = 0; k < 4; k++) dly.push_back(int'($urandom_range(1, 2)));
    dly.push_back(1);
    hits.push_back(1'($urandom_range(0, 1)));
    do_reset(r);
    rsp_di = 0; rsp_hi = 0;
    w = r + int'($urandom_range(1, 6));
    model(w + 1, 3);
    cm = -1;
    for (int c = w + 1; c < model_end && cm < 0; c++) begin
      if (exp_sel[c] == 3'd5 && !exp_st[c]) cm = c;
    end
    if (cm < 0) begin
      errors++;
      $display("FAIL mb_locate observed none expected a cycle");
    end else begin
      check_window(r + 1, w);
      i_init_done = 1'b1;
      check_window(w + 1, cm);
      chk("mb_done_driven", 32'(i_op_done), 1);
      i_reset = 1'b1;
      i_init_done = 1'b0;
      @(negedge clk);
      chk_zero();
      i_reset = 1'b0;
      for (int k = 0; k < FC + 10; k++) begin
        @(negedge clk);
        chk("wait_init_sel", 32'(o_op_sel), 0);
        chk("wait_init_busy", 32'(o_busy), 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
